// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame controller: output-mux selects,
// FSM states and parity types.
package uart_tx_pkg;

    localparam logic [1:0] START_SEL = 2'b00;
    localparam logic [1:0] STOP_SEL  = 2'b01;
    localparam logic [1:0] SER_SEL   = 2'b10;
    localparam logic [1:0] PAR_SEL   = 2'b11;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // The idle line and the stop bit share the same mux leg.
    function automatic logic [1:0] sel_for_state(input state_e s);
        logic [1:0] sel;
        sel = STOP_SEL;
        case (s)
            ST_START:  sel = START_SEL;
            ST_DATA:   sel = SER_SEL;
            ST_PARITY: sel = PAR_SEL;
            default:   sel = STOP_SEL;
        endcase
        return sel;
    endfunction

    function automatic logic frame_parity(input logic ones_odd, input logic par_typ);
        logic p;
        p = ones_odd;
        case (par_typ)
            EVEN:    p = ones_odd;
            ODD:     p = ~ones_odd;
            default: p = ones_odd;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Payload request and bit-selector mux drive between the system side and the
// TX frame controller.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first payload shifter with a bit counter that flags the last data bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_bit;

    assign last_bit = (cnt_q == LAST_CNT);

    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = P_DATA;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_data = shift_q[0];
    assign ser_done = shift_en & last_bit;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: accepts a byte in IDLE, then walks start, data,
// optional parity and stop, steering the output bit-selector mux.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_frame_ctrl_if.slave  bus
);

    state_e state_q, state_d;
    logic   par_bit_q, par_bit_d;
    logic   par_en_q, par_en_d;
    logic   load;
    logic   shift_en;
    logic   ser_bit;
    logic   ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .P_DATA   (bus.P_DATA),
        .ser_data (ser_bit),
        .ser_done (ser_done)
    );

    // Request inputs are only looked at in IDLE; mid-frame they are ignored.
    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.DATA_VALID) begin
                    load      = 1'b1;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = frame_parity(^bus.P_DATA, bus.PAR_TYP);
                    state_d   = ST_START;
                end
            end
            ST_START: state_d = ST_DATA;
            ST_DATA: begin
                shift_en = 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    assign bus.mux_sel  = sel_for_state(state_q);
    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.par_bit  = par_bit_q;
    assign bus.ser_data = ser_bit;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed steps plus random frames
// compared against a frame-level reference model.
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [1:0] sel;
        bit         is_data;
        logic       bit_v;
    } step_t;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones_of(input logic [DW-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) n++;
        end
        return n;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " idle_sel"}, 32'(bus.mux_sel), 32'h1);
        check({tag, " idle_busy"}, 32'(bus.Busy), 32'h0);
    endtask

    // Expected line sequence built from the frame rules: start, payload LSB first,
    // optional parity, stop. Parity makes the total count of ones even (or odd).
    task automatic run_frame(input string name, input logic [DW-1:0] data, input logic pen,
                             input logic ptyp, input bit keep_valid, input bit noise);
        step_t exp_q[$];
        step_t st;
        int    busy_cnt;
        logic  exp_par;

        busy_cnt = 0;
        exp_par  = ((ones_of(data) + int'(ptyp)) % 2) == 1;
        st = '{sel: 2'b00, is_data: 1'b0, bit_v: 1'b0};
        exp_q.push_back(st);
        for (int i = 0; i < DW; i++) begin
            st = '{sel: 2'b10, is_data: 1'b1, bit_v: data[i]};
            exp_q.push_back(st);
        end
        if (pen) begin
            st = '{sel: 2'b11, is_data: 1'b0, bit_v: 1'b0};
            exp_q.push_back(st);
        end
        st = '{sel: 2'b01, is_data: 1'b0, bit_v: 1'b0};
        exp_q.push_back(st);

        bus.P_DATA     = data;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        tick();

        foreach (exp_q[i]) begin
            check({name, " sel"}, 32'(bus.mux_sel), 32'(exp_q[i].sel));
            if (bus.Busy === 1'b1) busy_cnt++;
            if (exp_q[i].is_data) begin
                check({name, " ser"}, 32'(bus.ser_data), 32'(exp_q[i].bit_v));
            end
            if (i == 0 || exp_q[i].sel == 2'b11) begin
                check({name, " par"}, 32'(bus.par_bit), 32'(exp_par));
            end
            bus.P_DATA     = DW'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.DATA_VALID = keep_valid ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            tick();
        end

        check({name, " busy_len"}, 32'(busy_cnt), 32'(exp_q.size()));
        check_idle(name);
        bus.DATA_VALID = keep_valid;
    endtask

    initial begin
        logic [DW-1:0] d55;

        RST            = 1'b1;
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        // Reset held two cycles with a pending request that must be dropped.
        tick();
        check_idle("rst1");
        check("rst1 par", 32'(bus.par_bit), 32'h0);
        check("rst1 ser", 32'(bus.ser_data), 32'h0);
        tick();
        check_idle("rst2");
        RST            = 1'b0;
        bus.DATA_VALID = 1'b0;
        tick();
        check_idle("rst_release");

        // Directed frames: even, odd, no parity.
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back with DATA_VALID held: exactly one idle cycle between frames.
        run_frame("b2b_3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.P_DATA = 8'hC3;
        run_frame("b2b_c3", 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_idle("b2b_after");

        // Abort on the 4th data cycle, then a fresh complete frame.
        d55            = 8'h55;
        bus.P_DATA     = d55;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort data4 sel", 32'(bus.mux_sel), 32'h2);
        check("abort data4 ser", 32'(bus.ser_data), 32'(d55[3]));
        RST = 1'b1;
        tick();
        check_idle("abort");
        RST = 1'b0;
        tick();
        check_idle("abort_release");
        run_frame("after_abort", DW'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0);

        // Requests pulsed mid-frame only: nothing follows the frame.
        run_frame("noise", 8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_idle("noise_after1");
        tick();
        check_idle("noise_after2");

        for (int k = 0; k < 8; k++) begin
            run_frame("rand", DW'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            if (($urandom % 2) == 1) tick();
        end
        tick();
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
